fifo_fwft_lvl: RTL and testbench
================================

Name: fifo_fwft_lvl

Overview:
- Parametrised first-word-fall-through FIFO. It is the successor to the team's fixed-threshold FWFT FIFO.
- Adds: arbitrary depth, an exact fill-level output, programmable almost-full and almost-empty thresholds, sticky overflow/underflow flags, and a synchronous flush.
- Used as the general buffering element between streaming pipeline stages in the preprocessing datapath.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: total capacity in words, counting the output register. Must be >= 2.
- AFULL_THRESH, DEPTH-2: afull asserts when the level is >= this value. Range 1..DEPTH.
- AEMPTY_THRESH, 1: aempty asserts when the level is <= this value. Range 0..DEPTH-1.
- LVL_BITS, $clog2(DEPTH+1): width of the level output (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all contents.
- push  in  1  write request; din is captured when accepted.
- din  in  WIDTH  write data.
- pop  in  1  read acknowledge; consumes the current dout.
- dout  out  WIDTH  head-of-queue data; valid whenever empty=0.
- empty  out  1  no data available.
- full  out  1  level == DEPTH.
- afull  out  1  level >= AFULL_THRESH.
- aempty  out  1  level <= AEMPTY_THRESH.
- level  out  LVL_BITS  number of stored words, 0..DEPTH.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Storage: one output register (dout) plus a circular RAM of DEPTH-1 entries. The RAM has read/write pointers with a wrap-carry bit. Pointers wrap from DEPTH-2 to 0 and toggle the carry on wrap.
- Reset values: dout=0, empty=1, full=0, afull=0, aempty=1, level=0, overflow=0, underflow=0, all pointers and carry bits 0.
- Acceptance rules:
  - pop is accepted when empty=0.
  - push is accepted when full=0, or when full=1 and pop is accepted in the same cycle.
  - A rejected push sets overflow. A rejected pop sets underflow. In both cases storage is unchanged.
- Routing of an accepted push:
  - To the output register if the RAM is empty and (the output register is empty or an accepted pop occurs this cycle).
  - Otherwise to the RAM at wr_ptr.
- Accepted pop:
  - If the RAM is non-empty, the output register loads RAM[rd_ptr] at the clock edge.
  - Else if a push is routed to the output register this cycle, it loads din.
  - Else the output register clears to 0 and empty asserts.
- Latency:
  - Push into an empty FIFO: dout=din and empty=0 on the next cycle. This is the FWFT behaviour.
  - Pop: the next word appears on the following cycle with no bubble.
- Level arithmetic: level_next = level + push_acc - pop_acc, width LVL_BITS, no wrap.
- Flag timing: all flags (full, afull, aempty, empty) are registers computed from level_next, so they are exact in the cycle after the edge.
- Simultaneous push+pop:
  - When full: level stays DEPTH, full stays 1.
  - When empty: push accepted, pop rejected (underflow=1), level goes 0 to 1.
- Flush:
  - Next cycle equals the reset state, except that overflow and underflow are preserved.
  - Flush overrides push and pop in the same cycle; no error flags are set by that push or pop.
- err_clr: clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- RAM write is synchronous. The RAM read address is rd_ptr (registered) and the read is combinational from the array. The RAM is never read and written at the same address in a way that produces a hazard, because routing sends the first word to the output register.
- Asynchronous reset mid-operation: all state returns to the reset values immediately. RAM contents are don't-care.

Decomposition:
- Package fifo_pkg holds:
  - a clog2 helper function;
  - the threshold legality check (elaboration error if DEPTH<2, AFULL_THRESH outside 1..DEPTH, or AEMPTY_THRESH >= DEPTH).
- Sub-module fifo_ram: a simple dual-port array with parameters WIDTH and DEPTH-1, a synchronous write port and an asynchronous read port. It is kept separate so it can be mapped to vendor RAM later.

Test Plan (WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1):
- Single push 0xA5 into an empty FIFO -> next cycle dout=0xA5, empty=0, level=1, aempty=1. Pop -> next cycle empty=1, dout=0x00, level=0.
- Push 0x01..0x04 on back-to-back cycles -> afull=1 after the 3rd push, full=1 and level=4 after the 4th. A 5th push of 0x05 is rejected -> overflow=1, level=4. Four pops read 0x01,0x02,0x03,0x04 in order.
- Full FIFO, push 0x10 together with pop -> dout advances to the next word, level=4, full=1, no overflow. Drain yields 0x10 last.
- Empty FIFO, push 0x33 together with pop -> underflow=1, level=1, dout=0x33 next cycle.
- Continuous push+pop at level 2 for 10 cycles (RAM pointer wrap) -> output order matches input exactly, level stays 2.
- Level 3 with overflow=1: flush plus push 0x77 in the same cycle -> next cycle level=0, empty=1, overflow still 1. Then err_clr -> overflow=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the level-reporting FWFT FIFO.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
//
// Contents:
//   clog2      - ceiling log2, usable in parameter defaults
//   params_ok  - legality check on depth and the two fill thresholds
package fifo_pkg;

  // Ceiling log2. clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // DEPTH must be at least 2 (output register plus one RAM word).
  // afull must be reachable and non-trivial.
  // aempty must not cover a full FIFO.
  function automatic bit params_ok(input int depth, input int afull_thresh,
                                   input int aempty_thresh);
    return (depth >= 2) &&
           (afull_thresh >= 1) && (afull_thresh <= depth) &&
           (aempty_thresh >= 0) && (aempty_thresh < depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array behind the FIFO output register.
// Latency: write lands at the clock edge; the read is combinational from raddr.
// Backpressure: none; the caller guarantees it never writes a live entry.
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (asynchronous)
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset: contents are meaningless until the pointers say otherwise.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_fwft_lvl.sv
// First-word-fall-through FIFO with exact fill level, programmable almost-full
// and almost-empty thresholds, sticky overflow/underflow flags and a flush.
// Latency: a push into an empty FIFO shows on dout the next cycle; pops give
// back-to-back words with no bubble.
// Backpressure: a push while full (without an accepted pop) is dropped and sets
// overflow; a pop while empty is dropped and sets underflow.
//
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   flush                - synchronous clear of contents (error flags kept)
//   push, din            - write request and data
//   pop                  - consume the current dout
//   dout, empty          - head-of-queue word, valid while empty = 0
//   full, afull, aempty  - registered fill flags
//   level                - number of stored words, 0..DEPTH
//   err_clr              - clear the sticky error flags
//   overflow, underflow  - sticky rejected-push / rejected-pop flags
module fifo_fwft_lvl
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int LVL_BITS      = clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDTH-1:0]    din,
  input  logic                pop,
  output logic [WIDTH-1:0]    dout,
  output logic                empty,
  output logic                full,
  output logic                afull,
  output logic                aempty,
  output logic [LVL_BITS-1:0] level,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow
);

  // The output register holds one word, so the RAM only needs DEPTH-1.
  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int PTR_BITS  = (RAM_DEPTH > 1) ? clog2(RAM_DEPTH) : 1;
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(RAM_DEPTH - 1);
  localparam logic [LVL_BITS-1:0] LVL_DEPTH  = LVL_BITS'(DEPTH);
  localparam logic [LVL_BITS-1:0] LVL_AFULL  = LVL_BITS'(AFULL_THRESH);
  localparam logic [LVL_BITS-1:0] LVL_AEMPTY = LVL_BITS'(AEMPTY_THRESH);

  generate
    if (!params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
      $error("fifo_fwft_lvl: illegal DEPTH/AFULL_THRESH/AEMPTY_THRESH combination");
    end
  endgenerate

  // RAM pointers. The carry bit flips on every wrap, so equal pointers with
  // equal carries mean the RAM is empty and differing carries mean it is full.
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                wr_c;
  logic                rd_c;

  logic                ram_empty;
  logic                pop_acc;
  logic                push_acc;
  logic                push_to_out;
  logic                push_to_ram;
  logic                ram_rd;
  logic                ovf_set;
  logic                unf_set;
  logic [WIDTH-1:0]    ram_rdata;
  logic [LVL_BITS-1:0] level_next;

  assign ram_empty = (wr_ptr == rd_ptr) && (wr_c == rd_c);

  // Flush wins over both requests and suppresses their error reporting.
  assign pop_acc  = pop && !empty && !flush;
  assign push_acc = push && !flush && (!full || pop_acc);
  assign ovf_set  = push && !flush && !push_acc;
  assign unf_set  = pop && !flush && !pop_acc;

  // A word may only bypass the RAM when nothing older is waiting in it;
  // this also keeps the RAM from being read at the address just written.
  assign push_to_out = push_acc && ram_empty && (empty || pop_acc);
  assign push_to_ram = push_acc && !push_to_out;
  assign ram_rd      = pop_acc && !ram_empty;

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      unique case ({push_acc, pop_acc})
        2'b10:   level_next = level + LVL_BITS'(1);
        2'b01:   level_next = level - LVL_BITS'(1);
        default: level_next = level;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_DEPTH),
    .AW    (PTR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (push_to_ram),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // RAM pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      wr_c   <= 1'b0;
      rd_ptr <= '0;
      rd_c   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      wr_c   <= 1'b0;
      rd_ptr <= '0;
      rd_c   <= 1'b0;
    end else begin
      if (push_to_ram) begin
        if (wr_ptr == PTR_LAST) begin
          wr_ptr <= '0;
          wr_c   <= ~wr_c;
        end else begin
          wr_ptr <= wr_ptr + PTR_BITS'(1);
        end
      end
      if (ram_rd) begin
        if (rd_ptr == PTR_LAST) begin
          rd_ptr <= '0;
          rd_c   <= ~rd_c;
        end else begin
          rd_ptr <= rd_ptr + PTR_BITS'(1);
        end
      end
    end
  end

  // Output register: refilled from the RAM head first, then from a bypassing
  // push, otherwise cleared so an empty FIFO always shows zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (flush) begin
      dout <= '0;
    end else if (pop_acc) begin
      if (!ram_empty)       dout <= ram_rdata;
      else if (push_to_out) dout <= din;
      else                  dout <= '0;
    end else if (push_to_out) begin
      dout <= din;
    end
  end

  // Level and flags, all derived from the next level so they are exact as
  // soon as the edge that changes the contents has passed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      level  <= level_next;
      empty  <= (level_next == '0);
      full   <= (level_next == LVL_DEPTH);
      afull  <= (level_next >= LVL_AFULL);
      aempty <= (level_next <= LVL_AEMPTY);
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_fwft_lvl.sv
// Self-checking bench for fifo_fwft_lvl (WIDTH=8, DEPTH=4, AFULL=3, AEMPTY=1).
// Latency: checks every output one cycle after each stimulus edge.
// Backpressure: models rejected pushes/pops and the sticky error flags.
module tb_fifo_fwft_lvl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AFT      = 3;
  localparam int AET      = 1;
  localparam int LVL_BITS = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                push;
  logic [WIDTH-1:0]    din;
  logic                pop;
  logic [WIDTH-1:0]    dout;
  logic                empty;
  logic                full;
  logic                afull;
  logic                aempty;
  logic [LVL_BITS-1:0] level;
  logic                err_clr;
  logic                overflow;
  logic                underflow;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard: words expected at dout, oldest first.
  logic [WIDTH-1:0] m_q [$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_fwft_lvl #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFT),
    .AEMPTY_THRESH (AET),
    .LVL_BITS      (LVL_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .afull     (afull),
    .aempty    (aempty),
    .level     (level),
    .err_clr   (err_clr),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_state(input string tag);
    int n;
    n = m_q.size();
    chk({tag, "_level"},  32'(level),     32'(n));
    chk({tag, "_empty"},  32'(empty),     32'(n == 0));
    chk({tag, "_full"},   32'(full),      32'(n == DEPTH));
    chk({tag, "_afull"},  32'(afull),     32'(n >= AFT));
    chk({tag, "_aempty"}, 32'(aempty),    32'(n <= AET));
    chk({tag, "_ovf"},    32'(overflow),  32'(m_ovf));
    chk({tag, "_unf"},    32'(underflow), 32'(m_unf));
    if (n == 0) chk({tag, "_dout_idle"}, 32'(dout), 32'h0);
    else        chk({tag, "_dout"},      32'(dout), 32'(m_q[0]));
  endtask

  // One clock of stimulus; model decisions are taken from the model state only.
  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic q,
                      input logic f, input logic ec);
    logic pa;
    logic wa;
    push = p; din = d; pop = q; flush = f; err_clr = ec;
    pa = q && (m_q.size() > 0) && !f;
    wa = p && !f && ((m_q.size() < DEPTH) || pa);
    if (pa) chk("pop_data", 32'(dout), 32'(m_q[0]));
    @(posedge clk);
    #1;
    if (f) begin
      m_q.delete();
    end else begin
      if (pa) void'(m_q.pop_front());
      if (wa) m_q.push_back(d);
    end
    if (p && !f && !wa) m_ovf = 1'b1;
    else if (ec)        m_ovf = 1'b0;
    if (q && !f && !pa) m_unf = 1'b1;
    else if (ec)        m_unf = 1'b0;
    check_state("step");
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; push = 1'b0; din = '0; pop = 1'b0; err_clr = 1'b0;
    #12;
    check_state("reset");
    rst_n = 1'b1;

    // Single word through an empty FIFO.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_aempty", 32'(aempty), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_drained", 32'(empty), 32'h1);

    // Fill, overflow on the fifth push, drain in order.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("fill_afull3", 32'(afull), 32'h1);
    end
    chk("fill_ovf", 32'(overflow), 32'h1);
    chk("fill_level", 32'(level), 32'h4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push together with pop while full.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("fullpp_noovf", 32'(overflow), 32'h0);
    chk("fullpp_dout", 32'(dout), 32'h22);
    // err_clr in the same cycle as a new overflow keeps the flag set.
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push together with pop while empty.
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    chk("emptypp_unf", 32'(underflow), 32'h1);
    chk("emptypp_dout", 32'(dout), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Steady push+pop at level 2, wrapping the RAM pointers.
    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
    chk("stream_level", 32'(level), 32'h2);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with a simultaneous push at level 3 keeps the overflow flag.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 32'h0);
    chk("flush_ovf", 32'(overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("errclr_ovf", 32'(overflow), 32'h0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hCF, 1'b1, 1'b0, 1'b0);
    push = 1'b0; pop = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state("arst");
    pop = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
